// File: rtl/fifo_arbiter_if.sv
// Bundle of producer, FIFO-side and consumer signals around fifo_arbiter.
// Names carry the arbiter's view: i_* are arbiter inputs, o_* are arbiter outputs.
interface fifo_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    // Producer side
    logic [NUM_REQ-1:0]            i_req;
    logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data;
    logic [NUM_REQ-1:0]            o_gnt;

    // FIFO side (one-to-one with the FIFO instance ports)
    logic                          o_fifo_write_en;
    logic                          o_fifo_read_en;
    logic [DATA_WIDTH-1:0]         o_fifo_data_in;
    logic [DATA_WIDTH-1:0]         i_fifo_data_out;
    logic                          i_fifo_full;
    logic                          i_fifo_empty;

    // Consumer side
    logic                          o_out_valid;
    logic [DATA_WIDTH-1:0]         o_out_data;
    logic                          i_out_ready;

    // The arbiter itself
    modport master (
        input  i_req, i_req_data, i_fifo_data_out, i_fifo_full, i_fifo_empty, i_out_ready,
        output o_gnt, o_fifo_write_en, o_fifo_read_en, o_fifo_data_in, o_out_valid, o_out_data
    );

    // Everything around the arbiter: producers, FIFO and consumer
    modport slave (
        output i_req, i_req_data, i_fifo_data_out, i_fifo_full, i_fifo_empty, i_out_ready,
        input  o_gnt, o_fifo_write_en, o_fifo_read_en, o_fifo_data_in, o_out_valid, o_out_data
    );
endinterface

// File: rtl/fifo_arbiter.sv
// Scheduler sharing one single-port FIFO between NUM_REQ producers and one
// valid/ready consumer. Writes are round-robin arbitrated; reads are issued on
// behalf of the consumer with at most one read in flight. Write and read are
// never strobed together and alternate when both are eligible.
module fifo_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    fifo_arbiter_if.master bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Encoding of the last performed operation
    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_READ  = 1'b1;

    // Registered state
    logic [PTR_W-1:0]      r_rr_ptr;
    logic                  r_last_op;
    logic                  r_rd_pending;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;

    // Combinational decision signals
    logic                  w_found;
    logic [PTR_W-1:0]      w_winner;
    logic [PTR_W-1:0]      w_next_ptr;
    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic                  w_do_wr;
    logic                  w_do_rd;
    logic [NUM_REQ-1:0]    w_gnt;
    logic [DATA_WIDTH-1:0] w_data_in;

    // Round-robin search: first requester scanning from r_rr_ptr upward, wrapping
    always_comb begin
        int v_idx;
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        v_idx    = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_found && bus.i_req[v_idx]) begin
                w_found  = 1'b1;
                w_winner = PTR_W'(v_idx);
            end
        end
    end

    // Pointer moves one past the winner, wrapping from NUM_REQ-1 back to 0
    always_comb begin
        if (w_winner == PTR_W'(NUM_REQ - 1)) begin
            w_next_ptr = '0;
        end else begin
            w_next_ptr = w_winner + 1'b1;
        end
    end

    // Eligibility and write/read selection; outputs are forced low during reset
    always_comb begin
        w_wr_ok = w_found && !bus.i_fifo_full;
        // A read is allowed only if nothing is in flight and the output register
        // is free now or is being emptied by the consumer this very cycle.
        w_rd_ok = !bus.i_fifo_empty && !r_rd_pending && (!r_out_valid || bus.i_out_ready);
        w_do_wr = rst_n && w_wr_ok && (!w_rd_ok || (r_last_op == OP_READ));
        w_do_rd = rst_n && w_rd_ok && (!w_wr_ok || (r_last_op == OP_WRITE));
    end

    // Grant vector and write data of the winning producer
    always_comb begin
        w_gnt     = '0;
        w_data_in = '0;
        if (w_do_wr) begin
            w_gnt[w_winner] = 1'b1;
            w_data_in       = bus.i_req_data[w_winner*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Arbitration state: priority pointer and last performed operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr  <= '0;
            r_last_op <= OP_READ;
        end else begin
            // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
            if (w_do_wr) begin
                r_rr_ptr  <= w_next_ptr;
                r_last_op <= OP_WRITE;
            end else if (w_do_rd) begin
                r_last_op <= OP_READ;
            end
        end
    end

    // Read pipeline: capture FIFO data the cycle after a read, hand off to consumer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data register is reset too, so a read in flight at reset leaves nothing visible.
            r_rd_pending <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
        end else begin
            r_rd_pending <= w_do_rd;
            if (r_rd_pending) begin
                r_out_valid <= 1'b1;
                r_out_data  <= bus.i_fifo_data_out;
            end else if (r_out_valid && bus.i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.o_gnt           = w_gnt;
    assign bus.o_fifo_write_en = w_do_wr;
    assign bus.o_fifo_read_en  = w_do_rd;
    assign bus.o_fifo_data_in  = w_data_in;
    assign bus.o_out_valid     = r_out_valid;
    assign bus.o_out_data      = r_out_data;

    // Structural invariants of the scheduler
    a_no_dual_strobe: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.o_fifo_write_en && bus.o_fifo_read_en));
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(bus.o_gnt));
    a_gnt_needs_req: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.o_gnt & ~bus.i_req) == '0);
    a_single_read: assert property (@(posedge clk) disable iff (!rst_n)
        !(r_rd_pending && bus.o_fifo_read_en));

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter: the FIFO and producers are modelled by
// per-cycle stimulus rows with hand-computed expected outputs.
module tb_fifo_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;

    logic clk;
    logic rst_n;

    fifo_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

    fifo_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rst;    // pulse reset before this row
        logic [3:0]  req;
        logic [31:0] data;
        logic        full;
        logic        empty;
        logic        ready;
        logic [7:0]  dout;
        logic [3:0]  gnt;
        logic        we;
        logic        re;
        logic [7:0]  din;
        logic        ov;
        logic [7:0]  od;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] req, input logic [31:0] data, input logic full,
                         input logic empty, input logic ready, input logic [7:0] dout);
        bus.i_req           = req;
        bus.i_req_data      = data;
        bus.i_fifo_full     = full;
        bus.i_fifo_empty    = empty;
        bus.i_out_ready     = ready;
        bus.i_fifo_data_out = dout;
    endtask

    // Reset pulse; returns right after a falling edge with rst_n released
    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(4'b0, 32'h0, 1'b0, 1'b1, 1'b0, 8'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic [31:0] data,
                                input logic full, input logic empty, input logic ready,
                                input logic [7:0] dout, input logic [3:0] gnt, input logic we,
                                input logic re, input logic [7:0] din, input logic ov,
                                input logic [7:0] od);
        vec_t v;
        v.rst = rst; v.req = req; v.data = data; v.full = full; v.empty = empty;
        v.ready = ready; v.dout = dout; v.gnt = gnt; v.we = we; v.re = re;
        v.din = din; v.ov = ov; v.od = od;
        return v;
    endfunction

    initial begin
        // ---- Vector table: one row per clock cycle ----
        // Single write then read-through of A5 from producer 2
        vecs.push_back(mk(1, 4'b0100, 32'h00A50000, 0, 1, 1, 8'h00, 4'b0100, 1, 0, 8'hA5, 0, 8'h00));
        vecs.push_back(mk(0, 4'b0000, 32'h0,        0, 0, 1, 8'h00, 4'b0000, 0, 1, 8'h00, 0, 8'h00));
        vecs.push_back(mk(0, 4'b0000, 32'h0,        0, 1, 1, 8'hA5, 4'b0000, 0, 0, 8'h00, 0, 8'h00));
        vecs.push_back(mk(0, 4'b0000, 32'h0,        0, 1, 1, 8'h00, 4'b0000, 0, 0, 8'h00, 1, 8'hA5));
        vecs.push_back(mk(0, 4'b0000, 32'h0,        0, 1, 1, 8'h00, 4'b0000, 0, 0, 8'h00, 0, 8'hA5));
        // Round-robin 0,1,2,3,0 with one interleaved read
        vecs.push_back(mk(1, 4'b1111, 32'h13121110, 0, 1, 0, 8'h00, 4'b0001, 1, 0, 8'h10, 0, 8'h00));
        vecs.push_back(mk(0, 4'b1111, 32'h13121110, 0, 0, 0, 8'h00, 4'b0000, 0, 1, 8'h00, 0, 8'h00));
        vecs.push_back(mk(0, 4'b1111, 32'h13121110, 0, 0, 0, 8'h10, 4'b0010, 1, 0, 8'h11, 0, 8'h00));
        vecs.push_back(mk(0, 4'b1111, 32'h13121110, 0, 0, 0, 8'h00, 4'b0100, 1, 0, 8'h12, 1, 8'h10));
        vecs.push_back(mk(0, 4'b1111, 32'h13121110, 0, 0, 0, 8'h00, 4'b1000, 1, 0, 8'h13, 1, 8'h10));
        vecs.push_back(mk(0, 4'b1111, 32'h13121110, 0, 0, 0, 8'h00, 4'b0001, 1, 0, 8'h10, 1, 8'h10));
        // FIFO full stalls producer 1 until space frees
        vecs.push_back(mk(1, 4'b0010, 32'h00007700, 1, 0, 0, 8'h00, 4'b0000, 0, 1, 8'h00, 0, 8'h00));
        vecs.push_back(mk(0, 4'b0010, 32'h00007700, 1, 0, 0, 8'h55, 4'b0000, 0, 0, 8'h00, 0, 8'h00));
        vecs.push_back(mk(0, 4'b0010, 32'h00007700, 0, 0, 0, 8'h00, 4'b0010, 1, 0, 8'h77, 1, 8'h55));
        // Contention alternates write, read, write, ... starting with a write
        vecs.push_back(mk(1, 4'b0001, 32'h00000021, 0, 0, 1, 8'h00, 4'b0001, 1, 0, 8'h21, 0, 8'h00));
        vecs.push_back(mk(0, 4'b0001, 32'h00000021, 0, 0, 1, 8'h00, 4'b0000, 0, 1, 8'h00, 0, 8'h00));
        vecs.push_back(mk(0, 4'b0001, 32'h00000021, 0, 0, 1, 8'h44, 4'b0001, 1, 0, 8'h21, 0, 8'h00));
        vecs.push_back(mk(0, 4'b0001, 32'h00000021, 0, 0, 1, 8'h00, 4'b0000, 0, 1, 8'h00, 1, 8'h44));
        vecs.push_back(mk(0, 4'b0001, 32'h00000021, 0, 0, 1, 8'h66, 4'b0001, 1, 0, 8'h21, 0, 8'h44));
        vecs.push_back(mk(0, 4'b0001, 32'h00000021, 0, 0, 1, 8'h00, 4'b0000, 0, 1, 8'h00, 1, 8'h66));
        // Consumer back-pressure holds 3C for 5 cycles, then transfer + same-cycle read
        vecs.push_back(mk(1, 4'b0000, 32'h0, 0, 0, 0, 8'h00, 4'b0000, 0, 1, 8'h00, 0, 8'h00));
        vecs.push_back(mk(0, 4'b0000, 32'h0, 0, 0, 0, 8'h3C, 4'b0000, 0, 0, 8'h00, 0, 8'h00));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 4'b0000, 32'h0, 0, 0, 0, 8'h99, 4'b0000, 0, 0, 8'h00, 1, 8'h3C));
        vecs.push_back(mk(0, 4'b0000, 32'h0, 0, 0, 1, 8'h99, 4'b0000, 0, 1, 8'h00, 1, 8'h3C));
        vecs.push_back(mk(0, 4'b0000, 32'h0, 0, 0, 1, 8'h99, 4'b0000, 0, 0, 8'h00, 0, 8'h3C));
        vecs.push_back(mk(0, 4'b0000, 32'h0, 0, 1, 1, 8'h00, 4'b0000, 0, 0, 8'h00, 1, 8'h99));

        // ---- Outputs are all low while reset is held, even with live inputs ----
        rst_n = 1'b0;
        drive(4'b1111, 32'h13121110, 1'b0, 1'b0, 1'b1, 8'hFF);
        #3;
        check("rst gnt", 32'(bus.o_gnt), 32'h0);
        check("rst we",  32'(bus.o_fifo_write_en), 32'h0);
        check("rst re",  32'(bus.o_fifo_read_en), 32'h0);
        check("rst din", 32'(bus.o_fifo_data_in), 32'h0);
        check("rst ov",  32'(bus.o_out_valid), 32'h0);
        check("rst od",  32'(bus.o_out_data), 32'h0);

        // ---- Apply table ----
        foreach (vecs[i]) begin
            if (vecs[i].rst) pulse_reset();
            else @(negedge clk);
            drive(vecs[i].req, vecs[i].data, vecs[i].full, vecs[i].empty, vecs[i].ready, vecs[i].dout);
            #1;
            check($sformatf("row%0d gnt", i), 32'(bus.o_gnt),           32'(vecs[i].gnt));
            check($sformatf("row%0d we",  i), 32'(bus.o_fifo_write_en), 32'(vecs[i].we));
            check($sformatf("row%0d re",  i), 32'(bus.o_fifo_read_en),  32'(vecs[i].re));
            check($sformatf("row%0d din", i), 32'(bus.o_fifo_data_in),  32'(vecs[i].din));
            check($sformatf("row%0d ov",  i), 32'(bus.o_out_valid),     32'(vecs[i].ov));
            check($sformatf("row%0d od",  i), 32'(bus.o_out_data),      32'(vecs[i].od));
        end

        // ---- Reset mid-operation with a read in flight ----
        pulse_reset();
        drive(4'b0000, 32'h0, 1'b0, 1'b0, 1'b1, 8'h00);
        #1 check("mid read1 re", 32'(bus.o_fifo_read_en), 32'h1);
        @(negedge clk);
        drive(4'b0000, 32'h0, 1'b0, 1'b0, 1'b1, 8'h5A);
        #1 check("mid pend re", 32'(bus.o_fifo_read_en), 32'h0);
        @(negedge clk);
        drive(4'b0000, 32'h0, 1'b0, 1'b0, 1'b1, 8'h00);
        #1;
        check("mid cap ov", 32'(bus.o_out_valid), 32'h1);
        check("mid cap od", 32'(bus.o_out_data), 32'h5A);
        check("mid read2 re", 32'(bus.o_fifo_read_en), 32'h1);
        @(negedge clk);
        #1 check("mid pre-rst od", 32'(bus.o_out_data), 32'h5A);
        #1;
        rst_n = 1'b0;
        drive(4'b1111, 32'h13121110, 1'b0, 1'b0, 1'b1, 8'hEE);
        #1;
        check("mid rst ov",  32'(bus.o_out_valid), 32'h0);
        check("mid rst od",  32'(bus.o_out_data), 32'h0);
        check("mid rst gnt", 32'(bus.o_gnt), 32'h0);
        check("mid rst we",  32'(bus.o_fifo_write_en), 32'h0);
        check("mid rst re",  32'(bus.o_fifo_read_en), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post gnt",  32'(bus.o_gnt), 32'h1);
        check("post we",   32'(bus.o_fifo_write_en), 32'h1);
        check("post re",   32'(bus.o_fifo_read_en), 32'h0);
        check("post din",  32'(bus.o_fifo_data_in), 32'h10);
        check("post ov",   32'(bus.o_out_valid), 32'h0);
        @(negedge clk);
        #1;
        check("post2 re",  32'(bus.o_fifo_read_en), 32'h1);
        check("post2 gnt", 32'(bus.o_gnt), 32'h0);
        check("post2 ov",  32'(bus.o_out_valid), 32'h0);
        @(negedge clk);
        #1;
        check("post3 gnt", 32'(bus.o_gnt), 32'h2);
        check("post3 ov",  32'(bus.o_out_valid), 32'h0);
        @(negedge clk);
        #1;
        check("post4 ov",  32'(bus.o_out_valid), 32'h1);
        check("post4 od",  32'(bus.o_out_data), 32'hEE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
